// File: rtl/pattern_scan_pkg.sv
// Shared types and default sizes for the pattern scan scheduler.
package pattern_scan_pkg;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_WORD_W = 16;
    localparam int DEF_PAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pattern_scan_rr_arb.sv
// Requester arbiter: request vector plus search pointer -> one-hot grant and index.
// Define PATTERN_SCAN_FIXED_PRIO_EN for fixed priority (lowest index wins);
// otherwise the search starts at ptr and wraps from NREQ-1 to 0.
module pattern_scan_rr_arb #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            valid
);

`ifdef PATTERN_SCAN_FIXED_PRIO_EN
    // The pointer has no meaning under fixed priority.
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Walk from the highest index down so the lowest requesting index is the last writer.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = ID_W'(i);
                valid  = 1'b1;
            end
        end
    end
`else
    // Walk offsets from farthest to nearest so the requester closest to ptr wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                gnt                            = '0;
                gnt[(int'(ptr) + k) % NREQ]    = 1'b1;
                idx                            = ID_W'((int'(ptr) + k) % NREQ);
                valid                          = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/pattern_scan_sched.sv
// Pattern scan scheduler: arbitrates requesters, then shifts the granted word
// MSB-first through an overlapping pattern detector and reports the match count.
// Define PATTERN_SCAN_FIXED_PRIO_EN for fixed-priority arbitration (no rr pointer).
module pattern_scan_sched
    import pattern_scan_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int WORD_W = DEF_WORD_W,
    parameter int PAT_W  = DEF_PAT_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*WORD_W-1:0]      word_in,
    input  logic                        cfg_we,
    input  logic [PAT_W-1:0]            cfg_pat,
    output logic [NREQ-1:0]             gnt,
    output logic                        busy,
    output logic                        bit_out,
    output logic                        hit,
    output logic                        done,
    output logic [$clog2(NREQ)-1:0]     done_id,
    output logic [$clog2(WORD_W):0]     match_cnt
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(WORD_W) + 1;
    localparam logic [CNT_W-1:0] HIT_MIN  = CNT_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    state_t             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0]    idx_q, idx_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-1:0]   act_pat_q, act_pat_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic [CNT_W-1:0]   bits_q, bits_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0]    arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic [ID_W-1:0]    arb_ptr;
    logic               arb_valid;
    logic [PAT_W-1:0]   window;

    // Per-requester view of the packed word bus.
    logic [WORD_W-1:0]  word_arr [NREQ];
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
        assign word_arr[gi] = word_in[gi*WORD_W +: WORD_W];
    end

`ifdef PATTERN_SCAN_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    // Pointer moves just past the requester that was served once its scan reports.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == DONE) begin
            rr_ptr_d = (idx_q == ID_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    assign arb_ptr = rr_ptr_q;
`endif

    pattern_scan_rr_arb #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req   (req),
        .ptr   (arb_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Detector window: previously shifted bits followed by the current bit.
    assign bit_out = (state_q == SCAN) & shift_q[WORD_W-1];
    assign window  = {hist_q, bit_out};
    assign hit     = (state_q == SCAN) && (bits_q >= HIT_MIN) && (window == act_pat_q);

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign done_id   = (state_q == DONE) ? idx_q : '0;
    assign match_cnt = cnt_q;

    // Next-state and datapath updates for the IDLE -> LOAD -> SCAN -> DONE sequence.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        act_pat_d = act_pat_q;
        shift_d   = shift_q;
        hist_d    = hist_q;
        bits_d    = bits_q;
        cnt_d     = cnt_q;
        // The pattern register accepts writes at any time; a running scan uses its own copy.
        pat_d     = cfg_we ? cfg_pat : pat_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    idx_d   = arb_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d   = word_arr[idx_q];
                act_pat_d = pat_q;
                hist_d    = '0;
                bits_d    = '0;
                cnt_d     = '0;
                state_d   = SCAN;
            end
            SCAN: begin
                shift_d = shift_q << 1;
                hist_d  = window[PAT_W-2:0];
                bits_d  = bits_q + 1'b1;
                if (hit) cnt_d = cnt_q + 1'b1;
                if (bits_q == LAST_BIT) state_d = DONE;
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Grant, pattern, shift and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_q     <= '0;
            idx_q     <= '0;
            pat_q     <= '0;
            act_pat_q <= '0;
            shift_q   <= '0;
            hist_q    <= '0;
            bits_q    <= '0;
            cnt_q     <= '0;
        end else begin
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            pat_q     <= pat_d;
            act_pat_q <= act_pat_d;
            shift_q   <= shift_d;
            hist_q    <= hist_d;
            bits_q    <= bits_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pattern_scan_sched.sv
// Randomized bench for pattern_scan_sched with a behavioural scan model.
// Follows PATTERN_SCAN_FIXED_PRIO_EN when the design is built with it.
module tb_pattern_scan_sched;

    localparam int NREQ   = 4;
    localparam int WORD_W = 16;
    localparam int PAT_W  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] word_in;
    logic        cfg_we;
    logic [3:0]  cfg_pat;
    logic [3:0]  gnt;
    logic        busy;
    logic        bit_out;
    logic        hit;
    logic        done;
    logic [1:0]  done_id;
    logic [4:0]  match_cnt;

    logic [15:0] words [4];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          model_rr = 0;
    logic [3:0]  model_pat = 4'h0;
    int          cnt;

    assign word_in = {words[3], words[2], words[1], words[0]};

    always #5 clock = ~clock;

    pattern_scan_sched #(
        .NREQ   (NREQ),
        .WORD_W (WORD_W),
        .PAT_W  (PAT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .word_in   (word_in),
        .cfg_we    (cfg_we),
        .cfg_pat   (cfg_pat),
        .gnt       (gnt),
        .busy      (busy),
        .bit_out   (bit_out),
        .hit       (hit),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Which requester the scheduler should serve for a given request vector.
    function automatic int model_grant(input logic [3:0] rq);
`ifdef PATTERN_SCAN_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (rq[i]) return i;
`else
        for (int k = 0; k < 4; k++) if (rq[(model_rr + k) % 4]) return (model_rr + k) % 4;
`endif
        return 0;
    endfunction

    // Write the pattern register during an idle cycle with no requests.
    task automatic write_pat(input logic [3:0] v);
        req       = 4'h0;
        cfg_we    = 1'b1;
        cfg_pat   = v;
        model_pat = v;
        @(negedge clock);
        cfg_we = 1'b0;
        check_val("wr_idle_busy", busy, 0);
    endtask

    // One full transaction starting in an IDLE cycle just after a falling edge.
    task automatic run_scan(input logic [3:0] rq, input bit rand_mid, input int cfg_k,
                            input logic [3:0] cfg_val, input int rst_k, output int obs_cnt);
        int         g;
        int         exp_cnt;
        logic [15:0] wv;
        logic [3:0] act;
        logic [3:0] win;
        logic       exp_hit;
        req     = rq;
        g       = model_grant(rq);
        wv      = words[g];
        act     = model_pat;
        exp_cnt = 0;
        obs_cnt = -1;
        check_val("idle_busy", busy, 0);
        // LOAD cycle
        @(negedge clock);
        cfg_we = 1'b0;
        check_val("load_gnt", gnt, 32'(1 << g));
        check_val("load_busy", busy, 1);
        check_val("load_bit", bit_out, 0);
        check_val("load_hit", hit, 0);
        for (int k = 0; k < WORD_W; k++) begin
            @(negedge clock);
            win     = 4'(wv >> (15 - k));
            exp_hit = (k >= PAT_W - 1) && (win == act);
            if (exp_hit) exp_cnt++;
            check_val("scan_bit", bit_out, 32'(wv[15-k]));
            check_val("scan_hit", hit, 32'(exp_hit));
            check_val("scan_done", done, 0);
            check_val("scan_gnt", gnt, 32'(1 << g));
            if (k == rst_k) begin
                reset = 1'b0;
                #1;
                check_val("rst_gnt", gnt, 0);
                check_val("rst_busy", busy, 0);
                check_val("rst_done", done, 0);
                check_val("rst_hit", hit, 0);
                check_val("rst_bit", bit_out, 0);
                check_val("rst_done_id", done_id, 0);
                check_val("rst_match_cnt", match_cnt, 0);
                req       = 4'h0;
                cfg_we    = 1'b0;
                model_rr  = 0;
                model_pat = 4'h0;
                @(negedge clock);
                check_val("rst_hold_done", done, 0);
                check_val("rst_hold_busy", busy, 0);
                reset = 1'b1;
                $display("scan req=%b granted=%0d aborted by reset at scan cycle %0d", rq, g, k);
                return;
            end
            cfg_we = 1'b0;
            if (k == cfg_k) begin
                cfg_we    = 1'b1;
                cfg_pat   = cfg_val;
                model_pat = cfg_val;
            end else if (rand_mid && $urandom_range(0, 7) == 0) begin
                cfg_we    = 1'b1;
                cfg_pat   = 4'($urandom);
                model_pat = cfg_pat;
            end
            if (rand_mid) begin
                if ($urandom_range(0, 3) == 0) req = 4'($urandom);
                if ($urandom_range(0, 3) == 0) words[$urandom_range(0, 3)] = 16'($urandom);
            end
        end
        // DONE cycle
        @(negedge clock);
        check_val("done_pulse", done, 1);
        check_val("done_id", done_id, 32'(g));
        check_val("match_cnt", match_cnt, 32'(exp_cnt));
        check_val("done_gnt", gnt, 32'(1 << g));
        check_val("done_hit", hit, 0);
        check_val("done_bit", bit_out, 0);
        check_val("done_busy", busy, 1);
        obs_cnt = int'(match_cnt);
        cfg_we  = 1'b0;
`ifndef PATTERN_SCAN_FIXED_PRIO_EN
        model_rr = (g + 1) % 4;
`endif
        $display("scan req=%b granted=%0d word=%h pat=%b matches=%0d", rq, g, wv, act, exp_cnt);
        // back in IDLE
        @(negedge clock);
        check_val("post_done", done, 0);
        check_val("post_gnt", gnt, 0);
        check_val("post_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        req     = 4'hF;
        cfg_we  = 1'b0;
        cfg_pat = 4'h0;
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);

        // Reset state with all requests already high
        @(negedge clock);
        check_val("reset_gnt", gnt, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_done_id", done_id, 0);
        check_val("reset_match_cnt", match_cnt, 0);
        check_val("reset_hit", hit, 0);
        check_val("reset_bit", bit_out, 0);
        reset = 1'b1;

        // All requesters held high from reset
        for (int i = 0; i < 5; i++) run_scan(4'hF, 1'b0, -1, 4'h0, -1, cnt);

        // Alternating-bit word against 0101
        write_pat(4'b0101);
        words[0] = 16'h5555;
        run_scan(4'b0001, 1'b0, -1, 4'h0, -1, cnt);
        check_val("alt_word_cnt", cnt, 7);

        // All-zero word never matches 0101
        words[0] = 16'h0000;
        run_scan(4'b0001, 1'b0, -1, 4'h0, -1, cnt);
        check_val("zero_word_cnt", cnt, 0);

        // Pattern rewrite mid-scan only affects the following scan
        words[0] = 16'h5555;
        run_scan(4'b0001, 1'b0, 5, 4'b1111, -1, cnt);
        check_val("midcfg_cnt", cnt, 7);
        words[0] = 16'hFFFF;
        run_scan(4'b0001, 1'b0, -1, 4'h0, -1, cnt);
        check_val("ones_word_cnt", cnt, 13);

        // Lone requester gets back-to-back scans
        words[2] = 16'($urandom);
        run_scan(4'b0100, 1'b0, -1, 4'h0, -1, cnt);
        run_scan(4'b0100, 1'b0, -1, 4'h0, -1, cnt);

        // Two contenders: alternate under round robin, lower index starves the other under fixed priority
        for (int i = 0; i < 3; i++) run_scan(4'b1010, 1'b0, -1, 4'h0, -1, cnt);

        // Randomized traffic with pattern writes and request/word churn mid-scan
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                write_pat(4'($urandom));
            end else if ($urandom_range(0, 3) == 0) begin
                cfg_we    = 1'b1;
                cfg_pat   = 4'($urandom);
                model_pat = cfg_pat;
            end
            for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
            run_scan(4'($urandom_range(1, 15)), 1'b1, -1, 4'h0, -1, cnt);
        end

        // Reset in the middle of a scan, then arbitration restarts from index 0
        words[0] = 16'($urandom);
        words[1] = 16'($urandom);
        run_scan(4'b0001, 1'b0, -1, 4'h0, -1, cnt);
        run_scan(4'b0010, 1'b0, -1, 4'h0, 8, cnt);
        run_scan(4'hF, 1'b0, -1, 4'h0, -1, cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_scan_sched.md
PATTERN_SCAN_SCHED -- requirements
Module: pattern_scan_sched

Interface
REQ-001 Parameter NREQ, 4, number of requesters (2..8).
REQ-002 Parameter WORD_W, 16, bits per scan word (4..32).
REQ-003 Parameter PAT_W, 4, pattern length in bits (2..8, PAT_W <= WORD_W).
REQ-004 Port clock input 1: rising-edge clock.
REQ-005 Port reset input 1: reset, asynchronous, active-low; clock is clock.
REQ-006 Port req input NREQ: per-requester scan request, level.
REQ-007 Port word_in input NREQ*WORD_W: requester i word at bits [i*WORD_W +: WORD_W].
REQ-008 Port cfg_we input 1: pattern write strobe.
REQ-009 Port cfg_pat input PAT_W: pattern value, MSB is the first bit expected.
REQ-010 Port gnt output NREQ: one-hot grant, held from grant cycle through DONE.
REQ-011 Port busy output 1: high in any state other than IDLE.
REQ-012 Port bit_out output 1: bit currently fed to the detector.
REQ-013 Port hit output 1: Mealy match pulse for the current bit.
REQ-014 Port done output 1: one-cycle completion pulse.
REQ-015 Port done_id output clog2(NREQ): requester index of the completed scan.
REQ-016 Port match_cnt output clog2(WORD_W)+1: overlapping match count, valid while done is high.

Function
REQ-017 FSM states are IDLE, LOAD, SCAN and DONE.
REQ-018 IDLE: with any req high, the arbiter selects one requester, asserts its gnt bit and moves to LOAD in the next cycle.
REQ-019 Round-robin arbitration: search starts at rr_ptr and wraps at NREQ-1 -> 0; after DONE, rr_ptr <= granted+1 mod NREQ.
REQ-020 LOAD: capture the granted word into the shift register, capture cfg into the active pattern, and clear the bit counter, history and match_cnt.
REQ-021 SCAN: one bit per cycle, MSB-first; bit_out = shift register MSB; history <= {history[PAT_W-2:0], bit_out}.
REQ-022 hit = (bits_seen >= PAT_W-1) & ({history[PAT_W-2:0], bit_out} == active pattern), where bits_seen counts bits already shifted in SCAN; hit is combinational from state and bit_out.
REQ-023 Matches may overlap; match_cnt increments on every hit and never wraps, since its width covers WORD_W.
REQ-024 After WORD_W SCAN cycles, go to DONE: done=1, done_id=granted index, match_cnt holds the final count; next cycle go to IDLE with gnt cleared.
REQ-025 Latency: grant cycle to done = WORD_W+2 cycles; arbitration restarts in the cycle after DONE.
REQ-026 A cfg_we in IDLE updates the pattern register in the next cycle; a cfg_we while busy updates the register but does not affect the active scan.
REQ-027 A req deasserted mid-scan does not abort the scan; the scan completes and reports.
REQ-028 A req held high across DONE is rearbitrated normally; a lone requester gets back-to-back scans.
REQ-029 hit and bit_out are 0 outside SCAN.

Reset
REQ-030 Asynchronous reset (reset=0) forces IDLE, rr_ptr=0, pattern=0, and gnt=0, busy=0, done=0, done_id=0, match_cnt=0, hit=0, bit_out=0.
REQ-031 Reset during SCAN abandons the scan with no done pulse; after reset release, behaviour is identical to power-up.

Configuration
REQ-032 With macro PATTERN_SCAN_FIXED_PRIO_EN defined, arbitration is fixed priority (lowest index wins) and rr_ptr is not implemented.
REQ-033 Without PATTERN_SCAN_FIXED_PRIO_EN, round-robin per REQ-019 applies.

Structure
REQ-034 Package pattern_scan_pkg holds the FSM state enum typedef (IDLE, LOAD, SCAN, DONE) and default parameter constants.
REQ-035 Sub-module pattern_scan_rr_arb (request vector + pointer -> one-hot grant + index) contains the arbiter, including the macro switch.

Verification
REQ-036 pattern=4'b0101, req[0] with word 0x5555 -> done after 18 cycles, done_id=0, match_cnt=7, hit pulses on SCAN cycles 3,5,...,15.
REQ-037 pattern=4'b0101, word 0x0000 -> match_cnt=0, hit never asserts.
REQ-038 All four req high from reset -> grant order 0,1,2,3,0, each gnt one-hot and exclusive.
REQ-039 Reset pulled low on SCAN cycle 8 -> all outputs 0 immediately, no done; the next request is granted from index 0.
REQ-040 cfg_we with 4'b1111 during a 0x5555/0101 scan -> that scan reports 7; the next 0xFFFF scan reports 13.
REQ-041 With PATTERN_SCAN_FIXED_PRIO_EN defined, req[3] and req[1] held high -> requester 1 is served repeatedly and requester 3 is starved.
